// File: rtl/color_manager_sync_gen.sv
// Line timing generator: SYNC -> BACK -> ACTIVE -> FRONT with per-line latched lengths.
// Outputs are decoded from registered state, counter and shadow lengths only.
module color_manager_sync_gen #(
    parameter int SYNC_WIDTH       = 8,
    parameter int BACKPORCH_WIDTH  = 8,
    parameter int ACTIVE_WIDTH     = 12,
    parameter int FRONTPORCH_WIDTH = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Enable,
    input  logic [SYNC_WIDTH-1:0]       SyncLen,
    input  logic [BACKPORCH_WIDTH-1:0]  BackPorch,
    input  logic [ACTIVE_WIDTH-1:0]     ActiveLen,
    input  logic [FRONTPORCH_WIDTH-1:0] FrontPorch,
    output logic                        Sync,
    output logic                        Active,
    output logic [ACTIVE_WIDTH-1:0]     PixelCount,
    output logic                        LineDone
);

    localparam int SB_W  = (SYNC_WIDTH > BACKPORCH_WIDTH) ? SYNC_WIDTH : BACKPORCH_WIDTH;
    localparam int AF_W  = (ACTIVE_WIDTH > FRONTPORCH_WIDTH) ? ACTIVE_WIDTH : FRONTPORCH_WIDTH;
    localparam int CNT_W = (SB_W > AF_W) ? SB_W : AF_W;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SYNC   = 3'd1;
    localparam logic [2:0] BACK   = 3'd2;
    localparam logic [2:0] ACTIVE = 3'd3;
    localparam logic [2:0] FRONT  = 3'd4;

    logic [2:0]                  state, state_n;
    logic [CNT_W-1:0]            cnt, cnt_n;
    logic [SYNC_WIDTH-1:0]       sync_sh;
    logic [BACKPORCH_WIDTH-1:0]  back_sh;
    logic [ACTIVE_WIDTH-1:0]     active_sh;
    logic [FRONTPORCH_WIDTH-1:0] front_sh;

    logic [CNT_W-1:0] sync_w, back_w, active_w, front_w, cur_len;
    logic [2:0]       next_phase;
    logic             phase_last, line_end, load;

    // First non-empty phase following cur; IDLE marks the end of the line.
    function automatic logic [2:0] phase_after(input logic [2:0] cur, input logic has_back,
                                               input logic has_active, input logic has_front);
        logic [2:0] nxt;
        nxt = IDLE;
        case (cur)
            SYNC:    nxt = has_back ? BACK : has_active ? ACTIVE : has_front ? FRONT : IDLE;
            BACK:    nxt = has_active ? ACTIVE : has_front ? FRONT : IDLE;
            ACTIVE:  nxt = has_front ? FRONT : IDLE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // A zero sync length still yields a one-cycle pulse.
    assign sync_w   = (sync_sh == '0) ? CNT_W'(1) : CNT_W'(sync_sh);
    assign back_w   = CNT_W'(back_sh);
    assign active_w = CNT_W'(active_sh);
    assign front_w  = CNT_W'(front_sh);

    always_comb begin
        cur_len = CNT_W'(1);
        case (state)
            SYNC:    cur_len = sync_w;
            BACK:    cur_len = back_w;
            ACTIVE:  cur_len = active_w;
            FRONT:   cur_len = front_w;
            default: cur_len = CNT_W'(1);
        endcase
    end

    assign phase_last = (state != IDLE) && (cnt == cur_len - CNT_W'(1));
    assign next_phase = phase_after(state, back_w != '0, active_w != '0, front_w != '0);
    assign line_end   = phase_last && (next_phase == IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        load    = 1'b0;
        if (state == IDLE) begin
            cnt_n = '0;
            if (Enable) begin
                state_n = SYNC;
                load    = 1'b1;
            end
        end else if (line_end) begin
            cnt_n   = '0;
            state_n = Enable ? SYNC : IDLE;
            load    = Enable;
        end else if (phase_last) begin
            cnt_n   = '0;
            state_n = next_phase;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sync_sh   <= '0;
            back_sh   <= '0;
            active_sh <= '0;
            front_sh  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                sync_sh   <= SyncLen;
                back_sh   <= BackPorch;
                active_sh <= ActiveLen;
                front_sh  <= FrontPorch;
            end
        end
    end

    assign Sync       = (state == SYNC);
    assign Active     = (state == ACTIVE);
    assign PixelCount = (state == ACTIVE) ? cnt[ACTIVE_WIDTH-1:0] : '0;
    assign LineDone   = line_end;

endmodule

// File: tb/tb_color_manager_sync_gen.sv
// Directed bench for color_manager_sync_gen: per-cycle line waveforms checked against
// expectations derived from the programmed phase lengths.
module tb_color_manager_sync_gen;

    logic        Clk;
    logic        Rst;
    logic        Enable;
    logic [7:0]  SyncLen;
    logic [7:0]  BackPorch;
    logic [11:0] ActiveLen;
    logic [7:0]  FrontPorch;
    logic        Sync;
    logic        Active;
    logic [11:0] PixelCount;
    logic        LineDone;

    int checks = 0;
    int errors = 0;

    color_manager_sync_gen dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Enable     (Enable),
        .SyncLen    (SyncLen),
        .BackPorch  (BackPorch),
        .ActiveLen  (ActiveLen),
        .FrontPorch (FrontPorch),
        .Sync       (Sync),
        .Active     (Active),
        .PixelCount (PixelCount),
        .LineDone   (LineDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " sync"},   32'(Sync),       0);
        check({tag, " active"}, 32'(Active),     0);
        check({tag, " pixel"},  32'(PixelCount), 0);
        check({tag, " done"},   32'(LineDone),   0);
    endtask

    // Entered while observing cycle 0 of a line; returns observing the cycle after it.
    // At cycle mid_cyc (after checking) ActiveLen and Enable are overwritten.
    task automatic expect_line(input string tag, input int s, input int b, input int a,
                               input int f, input int mid_cyc, input int mid_active,
                               input logic mid_en);
        int se, period, e_px;
        logic e_sync, e_act, e_done;
        se     = (s == 0) ? 1 : s;
        period = se + b + a + f;
        for (int i = 0; i < period; i++) begin
            e_sync = (i < se);
            e_act  = (i >= se + b) && (i < se + b + a);
            e_px   = e_act ? (i - se - b) : 0;
            e_done = (i == period - 1);
            check($sformatf("%s c%0d sync", tag, i),   32'(Sync),       32'(e_sync));
            check($sformatf("%s c%0d active", tag, i), 32'(Active),     32'(e_act));
            check($sformatf("%s c%0d pixel", tag, i),  32'(PixelCount), 32'(e_px));
            check($sformatf("%s c%0d done", tag, i),   32'(LineDone),   32'(e_done));
            if (i == mid_cyc) begin
                ActiveLen = 12'(mid_active);
                Enable    = mid_en;
            end
            step();
        end
    endtask

    initial begin
        Rst        = 1'b1;
        Enable     = 1'b0;
        SyncLen    = 8'd2;
        BackPorch  = 8'd1;
        ActiveLen  = 12'd4;
        FrontPorch = 8'd8;
        step();
        step();
        Rst = 1'b0;
        check_idle("reset");
        step();
        check_idle("idle no enable");

        // Enable sampled at the next edge; Sync is visible in the following cycle.
        Enable = 1'b1;
        step();
        expect_line("L1 2/1/4/8", 2, 1, 4, 8, -1, 0, 1'b1);
        BackPorch = 8'd0;
        ActiveLen = 12'd0;
        expect_line("L2 2/1/4/8", 2, 1, 4, 8, -1, 0, 1'b1);
        expect_line("L3 2/0/0/8", 2, 0, 0, 8, -1, 0, 1'b1);
        SyncLen    = 8'd0;
        BackPorch  = 8'd1;
        ActiveLen  = 12'd1;
        FrontPorch = 8'd1;
        expect_line("L4 2/0/0/8", 2, 0, 0, 8, -1, 0, 1'b1);
        expect_line("L5 0/1/1/1", 0, 1, 1, 1, -1, 0, 1'b1);
        SyncLen    = 8'd2;
        BackPorch  = 8'd1;
        ActiveLen  = 12'd4;
        FrontPorch = 8'd8;
        expect_line("L6 0/1/1/1", 0, 1, 1, 1, -1, 0, 1'b1);

        // ActiveLen changed mid-ACTIVE only affects the following line.
        expect_line("L7 2/1/4/8", 2, 1, 4, 8, 4, 6, 1'b1);
        // Enable dropped mid-ACTIVE: line completes, then idle.
        expect_line("L8 2/1/6/8", 2, 1, 6, 8, 5, 6, 1'b0);
        check_idle("after drop");
        step();
        check_idle("after drop +1");
        step();
        check_idle("after drop +2");

        Enable = 1'b1;
        step();
        check("reenable sync", 32'(Sync), 1);
        step();
        check("reenable sync c1", 32'(Sync), 1);
        step();
        check("back sync", 32'(Sync), 0);
        check("back active", 32'(Active), 0);

        // Reset during BACK with Enable still high: reset wins, no LineDone.
        Rst = 1'b1;
        step();
        Rst    = 1'b0;
        Enable = 1'b0;
        check_idle("rst in back");
        step();
        check_idle("post rst +1");
        step();
        check_idle("post rst +2");

        Enable = 1'b1;
        step();
        expect_line("L9 2/1/6/8", 2, 1, 6, 8, -1, 0, 1'b1);
        check("L10 start sync", 32'(Sync), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_manager_sync_gen.md
COLOR_MANAGER_SYNC_GEN -- requirements
Module: color_manager_sync_gen

Interface
REQ-001 SHALL have parameter SYNC_WIDTH, default 8, bit width of SyncLen.
REQ-002 SHALL have parameter BACKPORCH_WIDTH, default 8, bit width of BackPorch.
REQ-003 SHALL have parameter ACTIVE_WIDTH, default 12, bit width of ActiveLen and PixelCount.
REQ-004 SHALL have parameter FRONTPORCH_WIDTH, default 8, bit width of FrontPorch.
REQ-005 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port Rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port Enable  input  1  run request; sampled in IDLE and at each line end.
REQ-008 SHALL have port SyncLen  input  SYNC_WIDTH  sync pulse length in cycles.
REQ-009 SHALL have port BackPorch  input  BACKPORCH_WIDTH  back-porch length in cycles.
REQ-010 SHALL have port ActiveLen  input  ACTIVE_WIDTH  active-region length in cycles.
REQ-011 SHALL have port FrontPorch  input  FRONTPORCH_WIDTH  front-porch length in cycles.
REQ-012 SHALL have port Sync  output  1  high exactly during SYNC state.
REQ-013 SHALL have port Active  output  1  high exactly during ACTIVE state.
REQ-014 SHALL have port PixelCount  output  ACTIVE_WIDTH  index within active region; 0 outside ACTIVE.
REQ-015 SHALL have port LineDone  output  1  one-cycle pulse on the last cycle of each line.

Function
REQ-016 SHALL implement FSM states IDLE, SYNC, BACK, ACTIVE, FRONT; outputs are Moore, decoded from registered state/counters only.
REQ-017 SHALL latch SyncLen, BackPorch, ActiveLen, FrontPorch into shadow registers on every transition into SYNC; input changes mid-line take effect next line only.
REQ-018 SHALL transition IDLE->SYNC on the edge where Enable=1 is sampled; Sync rises the following cycle (1-cycle latency).
REQ-019 SHALL hold each phase for exactly its latched length in cycles, using one phase counter of width max of all length widths, counting 0..len-1.
REQ-020 SHALL treat latched SyncLen=0 as 1 (sync never skipped).
REQ-021 SHALL skip any of BACK, ACTIVE, FRONT whose latched length is 0, proceeding directly to the next non-zero phase, with no extra cycle.
REQ-022 SHALL give a line period of max(SyncLen,1)+BackPorch+ActiveLen+FrontPorch cycles.
REQ-023 SHALL drive PixelCount = phase counter value during ACTIVE (0..ActiveLen-1), 0 otherwise.
REQ-024 SHALL assert LineDone on the final cycle of the last non-skipped phase of the line.
REQ-025 SHALL at line end go to SYNC (reloading shadows) if Enable=1, else to IDLE; lines are back-to-back with no gap cycle.
REQ-026 SHALL ignore Enable deassertion mid-line; the current line always completes.
REQ-027 SHALL keep Sync, Active, LineDone low and PixelCount 0 in IDLE.

Reset
REQ-028 SHALL on Rst=1 at a rising edge force state IDLE, phase counter 0, shadow registers 0, Sync=0, Active=0, PixelCount=0, LineDone=0 in the next cycle.
REQ-029 SHALL give Rst priority over Enable and abort any line in progress without a LineDone pulse.
REQ-030 SHALL after Rst deasserts require Enable=1 sampled in IDLE before a new line starts.

Verification
REQ-031 SHALL cover: SyncLen=2, BackPorch=1, ActiveLen=4, FrontPorch=8, Enable held 1 -> period 15; Sync 2 cycles, Active 4 cycles with PixelCount 0,1,2,3, LineDone once per line on last FRONT cycle, next Sync immediately after.
REQ-032 SHALL cover: ActiveLen=0, BackPorch=0, others as REQ-031 -> Active never high, period 10, Sync followed directly by FRONT.
REQ-033 SHALL cover: SyncLen=0, BackPorch=1, ActiveLen=1, FrontPorch=1 -> Sync high 1 cycle, period 4.
REQ-034 SHALL cover: ActiveLen changed 4->6 during ACTIVE -> current line keeps 4 active cycles, next line has 6.
REQ-035 SHALL cover: Enable dropped during ACTIVE -> line completes with LineDone, then IDLE; Enable reasserted -> Sync one cycle later.
REQ-036 SHALL cover: Rst pulsed 1 cycle during BACK -> next cycle all outputs 0, no LineDone, state IDLE; restart only on Enable.
